// File: rtl/stack_feeder.sv
// Program-nibble buffer that replays a loaded program onto a stack CPU inbits bus.
// Define STACK_FEEDER_LOOP_EN for looping playback; single-shot otherwise.
module stack_feeder #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_valid,
  input  logic [3:0] load_data,
  output logic       load_ready,
  input  logic       clear,
  input  logic       run,
  input  logic       abort,
  output logic [3:0] out_nibble,
  output logic       busy,
  output logic       done
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH5 = 5'(DEPTH);

  typedef enum logic [1:0] {IDLE, OPCODE, HOLD, DONE} state_t;

  state_t     state;
  logic [4:0] count;
  logic [4:0] pc;
  logic       hold_extra;
  logic [3:0] mem [DEPTH];

  logic       do_clear;
  logic       do_run;
  logic       do_load;
  logic [4:0] pc_plus1;
  logic [4:0] pc_plus2;
  logic [3:0] cur_nibble;
  logic [3:0] operand;
  logic       not_full;

  // clear outranks run, and run outranks a same-cycle load
  always_comb begin
    do_clear   = 1'b0;
    do_run     = 1'b0;
    do_load    = 1'b0;
    pc_plus1   = pc + 5'd1;
    pc_plus2   = pc + 5'd2;
    cur_nibble = mem[pc[AW-1:0]];
    operand    = 4'h0;
    not_full   = (count < DEPTH5);
    if (state == IDLE) begin
      do_clear = clear;
      do_run   = !clear && run && (count != 5'd0);
      do_load  = !clear && !do_run && load_valid && load_ready;
    end
    if (pc_plus1 != count) begin
      operand = mem[pc_plus1[AW-1:0]];
    end
  end

  // memory is deliberately left out of reset so programs survive it
  always_ff @(posedge clk) begin
    if (do_load) begin
      mem[count[AW-1:0]] <= load_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= 5'd0;
      pc         <= 5'd0;
      hold_extra <= 1'b0;
      out_nibble <= 4'h0;
      busy       <= 1'b0;
      done       <= 1'b0;
      load_ready <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (do_clear) begin
            count      <= 5'd0;
            load_ready <= 1'b1;
          end else if (do_run) begin
            state      <= OPCODE;
            pc         <= 5'd0;
            out_nibble <= mem[0];
            busy       <= 1'b1;
            load_ready <= 1'b0;
          end else if (do_load) begin
            count      <= count + 5'd1;
            load_ready <= ((count + 5'd1) < DEPTH5);
          end
        end

        OPCODE: begin
          if (abort) begin
            state      <= IDLE;
            out_nibble <= 4'h0;
            busy       <= 1'b0;
            hold_extra <= 1'b0;
            load_ready <= not_full;
          end else begin
            state <= HOLD;
            if (cur_nibble == 4'h1) begin
              out_nibble <= operand;
              hold_extra <= 1'b1;
              pc         <= pc_plus2;
            end else if (cur_nibble == 4'h2) begin
              out_nibble <= 4'h0;
              hold_extra <= 1'b1;
              pc         <= pc_plus1;
            end else begin
              out_nibble <= 4'h0;
              hold_extra <= 1'b0;
              pc         <= pc_plus1;
            end
          end
        end

        HOLD: begin
          if (abort) begin
            state      <= IDLE;
            out_nibble <= 4'h0;
            busy       <= 1'b0;
            hold_extra <= 1'b0;
            load_ready <= not_full;
          end else if (hold_extra) begin
            hold_extra <= 1'b0;
          end else if (pc < count) begin
            state      <= OPCODE;
            out_nibble <= cur_nibble;
          end else begin
`ifdef STACK_FEEDER_LOOP_EN
            state      <= OPCODE;
            pc         <= 5'd0;
            out_nibble <= mem[0];
            done       <= 1'b1;
`else
            state      <= DONE;
            out_nibble <= 4'h0;
            busy       <= 1'b0;
            done       <= 1'b1;
`endif
          end
        end

        DONE: begin
          state      <= IDLE;
          out_nibble <= 4'h0;
          busy       <= 1'b0;
          load_ready <= not_full;
        end

        default: begin
          state      <= IDLE;
          out_nibble <= 4'h0;
          busy       <= 1'b0;
          load_ready <= not_full;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_feeder.sv
// Directed self-checking bench for stack_feeder: vector table plus hand-written
// corner sequences (full memory, abort, async reset, looping when enabled).
module tb_stack_feeder;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_valid;
  logic [3:0] load_data;
  logic       load_ready;
  logic       clear;
  logic       run;
  logic       abort;
  logic [3:0] out_nibble;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       lv;
    logic [3:0] data;
    logic       clr;
    logic       run;
    logic       abt;
    logic [3:0] exp_out;
    logic       exp_busy;
    logic       exp_done;
    logic       exp_ready;
  } vec_t;

  vec_t vecs[$];

  stack_feeder #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .clear      (clear),
    .run        (run),
    .abort      (abort),
    .out_nibble (out_nibble),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  task automatic addVector(input logic lv, input logic [3:0] d, input logic clr,
                           input logic r, input logic abt, input logic [3:0] eo,
                           input logic eb, input logic ed, input logic er);
    vec_t v;
    v.lv = lv; v.data = d; v.clr = clr; v.run = r; v.abt = abt;
    v.exp_out = eo; v.exp_busy = eb; v.exp_done = ed; v.exp_ready = er;
    vecs.push_back(v);
  endtask

  // drive for one rising edge, then leave the bench 1 time unit past it
  task automatic applyStimulus(input logic lv, input logic [3:0] d, input logic clr,
                               input logic r, input logic abt);
    load_valid = lv;
    load_data  = d;
    clear      = clr;
    run        = r;
    abort      = abt;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    load_data  = 4'h0;
    clear      = 1'b0;
    run        = 1'b0;
    abort      = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] eo, input logic eb,
                             input logic ed, input logic er);
    checks++;
    if (out_nibble !== eo) begin
      failures++;
      $display("[TB] FAIL %s out_nibble got=%h exp=%h", name, out_nibble, eo);
    end
    checks++;
    if (busy !== eb) begin
      failures++;
      $display("[TB] FAIL %s busy got=%b exp=%b", name, busy, eb);
    end
    checks++;
    if (done !== ed) begin
      failures++;
      $display("[TB] FAIL %s done got=%b exp=%b", name, done, ed);
    end
    checks++;
    if (load_ready !== er) begin
      failures++;
      $display("[TB] FAIL %s load_ready got=%b exp=%b", name, load_ready, er);
    end
  endtask

  task automatic checkValue(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  initial begin
    int busy_cycles;
    int k;

    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_data  = 4'h0;
    clear      = 1'b0;
    run        = 1'b0;
    abort      = 1'b0;

    // reset state, then release between edges
    @(posedge clk); #1;
    checkOutput("in_reset", 4'h0, 1'b0, 1'b0, 1'b1);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("after_reset", 4'h0, 1'b0, 1'b0, 1'b1);

    // load 1,5,3 and run: 1,5,5,3,0 then DONE
    addVector(1, 4'h1, 0, 0, 0, 4'h0, 0, 0, 1);
    addVector(1, 4'h5, 0, 0, 0, 4'h0, 0, 0, 1);
    addVector(1, 4'h3, 0, 0, 0, 4'h0, 0, 0, 1);
    addVector(0, 4'h0, 0, 1, 0, 4'h1, 1, 0, 0);
    addVector(0, 4'h0, 0, 0, 0, 4'h5, 1, 0, 0);
    addVector(0, 4'h0, 0, 0, 0, 4'h5, 1, 0, 0);
    addVector(0, 4'h0, 0, 0, 0, 4'h3, 1, 0, 0);
    addVector(0, 4'h0, 0, 0, 0, 4'h0, 1, 0, 0);
    addVector(0, 4'h0, 0, 0, 0, 4'h0, 0, 1, 0);
    addVector(0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 1);
    // clear, load 2,3, run: 2,0,0,3,0 then DONE
    addVector(0, 4'h0, 1, 0, 0, 4'h0, 0, 0, 1);
    addVector(1, 4'h2, 0, 0, 0, 4'h0, 0, 0, 1);
    addVector(1, 4'h3, 0, 0, 0, 4'h0, 0, 0, 1);
    addVector(0, 4'h0, 0, 1, 0, 4'h2, 1, 0, 0);
    addVector(0, 4'h0, 0, 0, 0, 4'h0, 1, 0, 0);
    addVector(0, 4'h0, 0, 0, 0, 4'h0, 1, 0, 0);
    addVector(0, 4'h0, 0, 0, 0, 4'h3, 1, 0, 0);
    addVector(0, 4'h0, 0, 0, 0, 4'h0, 1, 0, 0);
    addVector(0, 4'h0, 0, 0, 0, 4'h0, 0, 1, 0);
    addVector(0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 1);
    // clear, load 3,1 (trailing PUSH; stale mem[2]=3 must not leak out)
    addVector(0, 4'h0, 1, 0, 0, 4'h0, 0, 0, 1);
    addVector(1, 4'h3, 0, 0, 0, 4'h0, 0, 0, 1);
    addVector(1, 4'h1, 0, 0, 0, 4'h0, 0, 0, 1);
    addVector(0, 4'h0, 0, 1, 0, 4'h3, 1, 0, 0);
    addVector(0, 4'h0, 0, 0, 0, 4'h0, 1, 0, 0);
    addVector(0, 4'h0, 0, 0, 0, 4'h1, 1, 0, 0);
    addVector(0, 4'h0, 0, 0, 0, 4'h0, 1, 0, 0);
    addVector(0, 4'h0, 0, 0, 0, 4'h0, 1, 0, 0);
    addVector(0, 4'h0, 0, 0, 0, 4'h0, 0, 1, 0);
    addVector(0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 1);
    // run on empty memory is ignored; clear beats same-cycle load and run
    addVector(0, 4'h0, 1, 0, 0, 4'h0, 0, 0, 1);
    addVector(0, 4'h0, 0, 1, 0, 4'h0, 0, 0, 1);
    addVector(1, 4'h4, 0, 0, 0, 4'h0, 0, 0, 1);
    addVector(1, 4'h7, 1, 1, 0, 4'h0, 0, 0, 1);
    addVector(0, 4'h0, 0, 1, 0, 4'h0, 0, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].lv, vecs[i].data, vecs[i].clr, vecs[i].run, vecs[i].abt);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_busy,
                  vecs[i].exp_done, vecs[i].exp_ready);
    end

    // fill memory with OUT opcodes; the extra PUSH nibble must be dropped
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1, 4'h3, 0, 0, 0);
      checkValue($sformatf("fill%0d_ready", i), int'(load_ready), (i + 1 < DEPTH) ? 1 : 0);
    end
    applyStimulus(1, 4'h1, 0, 0, 0);
    checkOutput("full_drop", 4'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(0, 4'h0, 0, 1, 0);
    busy_cycles = 0;
    k = 0;
    while (done !== 1'b1 && k < 200) begin
      if (busy === 1'b1) busy_cycles++;
      applyStimulus(0, 4'h0, 0, 0, 0);
      k++;
    end
    checkValue("full_done_seen", int'(done === 1'b1), 1);
    checkValue("full_busy_cycles", busy_cycles, 2 * DEPTH);
    applyStimulus(0, 4'h0, 0, 0, 0);
    checkOutput("full_back_idle", 4'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(0, 4'h0, 1, 0, 0);
    checkOutput("full_clear", 4'h0, 1'b0, 1'b0, 1'b1);

    // abort on the second PUSH hold cycle, then replay from the start
    applyStimulus(1, 4'h1, 0, 0, 0);
    applyStimulus(1, 4'h9, 0, 0, 0);
    applyStimulus(1, 4'h3, 0, 0, 0);
    applyStimulus(0, 4'h0, 0, 1, 0);
    checkOutput("ab_op", 4'h1, 1'b1, 1'b0, 1'b0);
    applyStimulus(0, 4'h0, 0, 0, 0);
    checkOutput("ab_hold1", 4'h9, 1'b1, 1'b0, 1'b0);
    applyStimulus(0, 4'h0, 0, 0, 0);
    checkOutput("ab_hold2", 4'h9, 1'b1, 1'b0, 1'b0);
    applyStimulus(0, 4'h0, 0, 0, 1);
    checkOutput("ab_idle", 4'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus(0, 4'h0, 0, 0, 0);
    checkOutput("ab_nodone", 4'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus(0, 4'h0, 0, 1, 0);
    checkOutput("re_op1", 4'h1, 1'b1, 1'b0, 1'b0);
    applyStimulus(0, 4'h0, 0, 0, 0);
    checkOutput("re_h1", 4'h9, 1'b1, 1'b0, 1'b0);
    applyStimulus(0, 4'h0, 0, 0, 0);
    checkOutput("re_h2", 4'h9, 1'b1, 1'b0, 1'b0);
    applyStimulus(0, 4'h0, 0, 0, 0);
    checkOutput("re_op3", 4'h3, 1'b1, 1'b0, 1'b0);
    applyStimulus(0, 4'h0, 0, 0, 0);
    checkOutput("re_h3", 4'h0, 1'b1, 1'b0, 1'b0);
`ifdef STACK_FEEDER_LOOP_EN
    applyStimulus(0, 4'h0, 0, 0, 0);
    checkOutput("re_loop", 4'h1, 1'b1, 1'b1, 1'b0);
    applyStimulus(0, 4'h0, 0, 0, 1);
    checkOutput("re_loop_abort", 4'h0, 1'b0, 1'b0, 1'b1);
`else
    applyStimulus(0, 4'h0, 0, 0, 0);
    checkOutput("re_done", 4'h0, 1'b0, 1'b1, 1'b0);
    applyStimulus(0, 4'h0, 0, 0, 0);
    checkOutput("re_idle", 4'h0, 1'b0, 1'b0, 1'b1);
`endif

    // asynchronous reset mid-playback
    applyStimulus(0, 4'h0, 0, 1, 0);
    checkOutput("rst_op", 4'h1, 1'b1, 1'b0, 1'b0);
    applyStimulus(0, 4'h0, 0, 0, 0);
    checkOutput("rst_hold", 4'h9, 1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_async", 4'h0, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #2;
    rst_n = 1'b1;
    applyStimulus(0, 4'h0, 0, 1, 0);
    checkOutput("rst_count0", 4'h0, 1'b0, 1'b0, 1'b1);

`ifdef STACK_FEEDER_LOOP_EN
    // looping program "3": 3,0,3,0,... with done on each wrap
    applyStimulus(1, 4'h3, 0, 0, 0);
    applyStimulus(0, 4'h0, 0, 1, 0);
    checkOutput("lp0", 4'h3, 1'b1, 1'b0, 1'b0);
    applyStimulus(0, 4'h0, 0, 0, 0);
    checkOutput("lp1", 4'h0, 1'b1, 1'b0, 1'b0);
    applyStimulus(0, 4'h0, 0, 0, 0);
    checkOutput("lp2", 4'h3, 1'b1, 1'b1, 1'b0);
    applyStimulus(0, 4'h0, 0, 0, 0);
    checkOutput("lp3", 4'h0, 1'b1, 1'b0, 1'b0);
    applyStimulus(0, 4'h0, 0, 0, 0);
    checkOutput("lp4", 4'h3, 1'b1, 1'b1, 1'b0);
    applyStimulus(0, 4'h0, 0, 0, 1);
    checkOutput("lp_abort", 4'h0, 1'b0, 1'b0, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stack_feeder.md
STACK_FEEDER -- requirements
Module: stack_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 16, program memory depth in 4-bit nibbles (power of two, 4..16).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port load_valid  input  1  program nibble present on load_data.
REQ-005 SHALL have port load_data  input  4  program nibble (opcode or PUSH operand).
REQ-006 SHALL have port load_ready  output  1  memory accepts a nibble this cycle.
REQ-007 SHALL have port clear  input  1  synchronous request to empty the program memory.
REQ-008 SHALL have port run  input  1  start playback of the loaded program.
REQ-009 SHALL have port abort  input  1  synchronous stop of playback.
REQ-010 SHALL have port out_nibble  output  4  registered nibble for the stack CPU inbits bus.
REQ-011 SHALL have port busy  output  1  playback in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse when playback completes.

Function
REQ-013 SHALL implement FSM states IDLE, OPCODE, HOLD, DONE; all outputs registered.
REQ-014 In IDLE, load_ready SHALL equal (count < DEPTH); count is the 5-bit number of stored nibbles.
REQ-015 In IDLE, load_valid && load_ready SHALL write mem[count] <= load_data and increment count; load_valid while full is dropped and count is held.
REQ-016 clear in IDLE SHALL set count to 0 next cycle and takes priority over a same-cycle load or run; clear outside IDLE is ignored.
REQ-017 run in IDLE with count > 0 SHALL set pc to 0 and enter OPCODE; run with count == 0 is ignored; run outside IDLE is ignored.
REQ-018 In OPCODE, out_nibble SHALL be mem[pc] for exactly one cycle; busy SHALL be 1 in OPCODE and HOLD.
REQ-019 Opcode 4'h1 (PUSH) SHALL enter HOLD for 2 cycles presenting mem[pc+1], advancing pc by 2; if pc+1 == count, the operand presented SHALL be 4'h0.
REQ-020 Opcode 4'h2 (POP) SHALL enter HOLD for 2 cycles presenting 4'h0, advancing pc by 1.
REQ-021 Opcode 4'h3 (OUT) and all other opcodes SHALL enter HOLD for 1 cycle presenting 4'h0, advancing pc by 1.
REQ-022 This gives per-instruction lengths of PUSH 3, POP 3, OUT/other 2 cycles, matching the CPU's fetch-to-fetch spacing.
REQ-023 At the end of HOLD, the FSM SHALL go to OPCODE if pc < count, else to DONE.
REQ-024 DONE SHALL last one cycle with done=1, busy=0, out_nibble=4'h0, then return to IDLE with count preserved.
REQ-025 abort in OPCODE or HOLD SHALL go to IDLE next cycle with out_nibble=4'h0, busy=0, no done pulse, and memory and count intact.
REQ-026 In IDLE and DONE, out_nibble SHALL be 4'h0 (NOOP).
REQ-027 Memory contents SHALL persist across playbacks and clear; only count is reset.

Reset
REQ-028 While rst_n=0: state=IDLE, count=0, pc=0, out_nibble=4'h0, busy=0, done=0, and load_ready=1 after release; memory contents are not reset.
REQ-029 Reset asserted mid-playback SHALL abandon the program immediately (asynchronously), with no done pulse.

Configuration
REQ-030 Macro STACK_FEEDER_LOOP_EN SHALL select looping playback.
REQ-031 With STACK_FEEDER_LOOP_EN defined, end-of-program SHALL pulse done for one cycle while going directly from HOLD to OPCODE with pc=0 (no DONE state, busy stays 1); only abort or reset stops playback.
REQ-032 Without STACK_FEEDER_LOOP_EN, behaviour SHALL be per REQ-023/024 (single-shot).

Verification
REQ-033 Load 1,5,3 then run -> out_nibble sequence 1,5,5,3,0 then 0 with done=1 on the DONE cycle; busy high for exactly 5 cycles.
REQ-034 Load 2,3 then run -> out_nibble 2,0,0,3,0; next cycle done=1.
REQ-035 Load DEPTH nibbles -> load_ready=0; an extra load_valid is dropped, count stays DEPTH; clear -> count=0, load_ready=1.
REQ-036 Load 3,1 (trailing PUSH without operand) then run -> out_nibble 3,0,1,0,0 then done.
REQ-037 abort on the 2nd cycle of PUSH HOLD -> IDLE next cycle, out_nibble=0, no done; a rerun replays from pc=0.
REQ-038 rst_n low mid-playback -> outputs immediately 0 and count=0; with STACK_FEEDER_LOOP_EN, program 3 run -> 3,0,3,0,... with done pulsing every 2 cycles.
